mac_accum: RTL and testbench
============================

# mac_accum

Parametrised, multi-channel signed multiply-accumulate block on the common `clk100` domain. It is the next generation of the single registered 8x8 multiplier in the common logic. Each of `CHANNELS` lanes multiplies signed `DATA_W`-bit operand pairs and accumulates `ACC_LEN` products into a full-precision result. Results are handed off through a valid/ready output register with backpressure to the input. Board-specific wrappers instantiate it with their own channel counts.

## Interface
- `DATA_W`, 8: operand width per lane, signed two's complement, >= 2.
- `CHANNELS`, 2: number of independent lanes, >= 1.
- `ACC_LEN`, 16: products per result, >= 2, power of two not required.
- `OUT_W`, derived localparam = 2*`DATA_W` + $clog2(`ACC_LEN`): result width per lane, signed; cannot overflow.

Ports:
- `clk100`  in  1  sole clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `flush`  in  1  synchronous discard of the partial accumulation.
- `in_valid`  in  1  operand set present.
- `in_ready`  out  1  block accepts operands this cycle.
- `mult_a`  in  `CHANNELS`*`DATA_W`  lane i at bits [i*`DATA_W` +: `DATA_W`].
- `mult_b`  in  `CHANNELS`*`DATA_W`  same packing as `mult_a`.
- `out_valid`  out  1  `acc_out` holds a completed result.
- `out_ready`  in  1  downstream accepts the result.
- `acc_out`  out  `CHANNELS`*`OUT_W`  lane i at bits [i*`OUT_W` +: `OUT_W`].

## Operation
- Accept: an operand set is taken on a rising edge where `in_valid` && `in_ready`.
- Pipeline: S1 operand registers with a valid bit → S2 signed product registers (2*`DATA_W` bits) with a valid bit → accumulator plus a sample counter 0..`ACC_LEN`-1 → output register.
- Stall: `en` = !(`out_valid` && !`out_ready`). `in_ready` = `en`. When `en` = 0, S1, S2, the accumulator and the counter all hold.
- Accumulate: when `en` and S2 valid:
  - If counter < `ACC_LEN`-1: accumulator += sign-extended product, counter++.
  - If counter = `ACC_LEN`-1: output register ← accumulator + product, accumulator ← 0, counter ← 0, `out_valid` ← 1.
- Output handshake:
  - `out_valid` clears on an edge with `out_ready` = 1 unless a new result loads on the same edge; if one loads, `out_valid` stays 1 and `acc_out` updates.
  - `acc_out` holds stable while `out_valid` && !`out_ready`.
- Lanes share the counter and handshake; per-lane arithmetic is independent.
- `flush` (when `reset` = 0):
  - Clears S1/S2 valid bits, the accumulator and the counter.
  - Does not touch the output register or `out_valid`.
  - Inputs presented in the same cycle are accepted per the normal handshake but then dropped.
- Reset:
  - Clears S1/S2 valid bits, the accumulator, the counter, `out_valid` and `acc_out`.
  - `in_ready` reads 1 in the cycle following reset.
  - Reset mid-accumulation discards all partial data.
  - `reset` has priority over `flush`.

## Timing
- Latency: operand set accepted at edge T reaches S1 at T, S2 at T+1, and accumulator/output at T+2. If that set completes a group, `out_valid` is high after edge T+2.
- Throughput: one operand set per cycle with no stall; one result per `ACC_LEN` cycles.
- Reset values: `out_valid` = 0, `acc_out` = 0, `in_ready` = 1.
- `in_ready` is combinational from `out_valid` and `out_ready`; there is no combinational path from `in_valid` to any output.
- Result is exact for all inputs, including all-minimum operands: (-2^(`DATA_W`-1))^2 × `ACC_LEN` fits in `OUT_W` signed.

## Test plan
- Basic, `CHANNELS`=2, `ACC_LEN`=4, `out_ready`=1:
  - Stimulus: 4 back-to-back sets, lane0 a=3 b=4, lane1 a=-2 b=5.
  - Response: one `out_valid` pulse 3 cycles after the last accept with lane0 = 48 and lane1 = -40.
- Extremes:
  - Stimulus: lane0 a=-128 b=-128 ×4, lane1 a=-128 b=127 ×4.
  - Response: lane0 = 65536, lane1 = -65024, no overflow in 18-bit output.
- Backpressure:
  - Stimulus: hold `out_ready`=0 with continuous `in_valid`.
  - Response: after the first result, `in_ready`=0 and `acc_out` stable. On `out_ready`=1, the next result follows with no lost or duplicated samples; check a running count 1..12 over 3 groups with sums 10, 26, 42 for a=k, b=1.
- Gapped input:
  - Stimulus: `in_valid` toggling every other cycle.
  - Response: same sums as gap-free; result 3 cycles after the 4th accept.
- Flush:
  - Stimulus: 2 samples (a=5, b=5), `flush`, then 4 samples (a=1, b=1).
  - Response: result = 4. An earlier result pending at `out_valid` is unaffected.
- Reset mid-operation:
  - Stimulus: assert `reset` after 3 samples with a result pending.
  - Response: `out_valid`=0, `acc_out`=0, and the next 4 samples (a=2, b=3) give 24.

Source files
------------

// File: rtl/mac_accum_if.sv
// mac_accum_if: operand/result handshake bundle for mac_accum.
//   in_valid/in_ready      operand-set handshake (master -> slave)
//   mult_a/mult_b          packed signed operands, lane i at [i*DATA_W +: DATA_W]
//   out_valid/out_ready    result handshake (slave -> master)
//   acc_out                packed signed results, lane i at [i*OUT_W +: OUT_W]
// master: the side producing operands and consuming results; slave: the MAC.
interface mac_accum_if #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned ACC_LEN  = 16
);
  localparam int unsigned OUT_W = 2 * DATA_W + $clog2(ACC_LEN);

  logic                         in_valid;
  logic                         in_ready;
  logic [CHANNELS*DATA_W-1:0]   mult_a;
  logic [CHANNELS*DATA_W-1:0]   mult_b;
  logic                         out_valid;
  logic                         out_ready;
  logic [CHANNELS*OUT_W-1:0]    acc_out;

  modport master (
    output in_valid, mult_a, mult_b, out_ready,
    input  in_ready, out_valid, acc_out
  );

  modport slave (
    input  in_valid, mult_a, mult_b, out_ready,
    output in_ready, out_valid, acc_out
  );
endinterface

// File: rtl/mac_accum.sv
// mac_accum: multi-lane signed multiply-accumulate with valid/ready handoff.
// Each lane multiplies signed DATA_W operand pairs and sums ACC_LEN products
// into a full-precision OUT_W result. Pipeline: S1 operands -> S2 products ->
// accumulator/counter -> output register. A stalled output freezes the whole
// pipeline and deasserts in_ready.
// Ports:
//   clk100  rising-edge clock
//   reset   synchronous active-high reset (priority over flush)
//   flush   synchronous discard of in-flight and partially accumulated data
//   bus     mac_accum_if slave: operand and result handshakes
module mac_accum #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned ACC_LEN  = 16
) (
  input logic        clk100,
  input logic        reset,
  input logic        flush,
  mac_accum_if.slave bus
);
  localparam int unsigned CNT_W  = $clog2(ACC_LEN);
  localparam int unsigned PROD_W = 2 * DATA_W;
  localparam int unsigned OUT_W  = PROD_W + CNT_W;
  localparam int unsigned EXT_W  = OUT_W - PROD_W;
  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(ACC_LEN - 1);

  logic                              en;
  logic                              last;
  logic                              s1_valid_q, s1_valid_d;
  logic [CHANNELS*DATA_W-1:0]        s1_a_q, s1_a_d, s1_b_q, s1_b_d;
  logic                              s2_valid_q, s2_valid_d;
  logic [CHANNELS-1:0][PROD_W-1:0]   prod, prod_q, prod_d;
  logic [CHANNELS-1:0][OUT_W-1:0]    sum, acc_q, acc_d, res_q, res_d;
  logic [CNT_W-1:0]                  cnt_q, cnt_d;
  logic                              out_valid_q, out_valid_d;

  // Pipeline advances unless a held result is waiting on downstream.
  assign en   = !(out_valid_q && !bus.out_ready);
  assign last = (cnt_q == LastCnt);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
    logic signed [PROD_W-1:0] a_ext, b_ext;
    // Sign-extend before multiplying so the product is exact at PROD_W.
    assign a_ext   = PROD_W'($signed(s1_a_q[i*DATA_W +: DATA_W]));
    assign b_ext   = PROD_W'($signed(s1_b_q[i*DATA_W +: DATA_W]));
    assign prod[i] = a_ext * b_ext;
    assign sum[i]  = acc_q[i] + {{EXT_W{prod_q[i][PROD_W-1]}}, prod_q[i]};
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    s2_valid_d  = s2_valid_q;
    prod_d      = prod_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    res_d       = res_q;
    out_valid_d = out_valid_q;

    if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end

    if (flush) begin
      // Output register is deliberately left alone; any operands accepted
      // this cycle are dropped by clearing the S1 valid bit.
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
      acc_d      = '0;
      cnt_d      = '0;
    end else if (en) begin
      s1_valid_d = bus.in_valid;
      s1_a_d     = bus.mult_a;
      s1_b_d     = bus.mult_b;
      s2_valid_d = s1_valid_q;
      prod_d     = prod;
      if (s2_valid_q) begin
        if (last) begin
          res_d       = sum;
          out_valid_d = 1'b1;
          acc_d       = '0;
          cnt_d       = '0;
        end else begin
          acc_d = sum;
          cnt_d = cnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk100) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s2_valid_q  <= 1'b0;
      prod_q      <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      res_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s2_valid_q  <= s2_valid_d;
      prod_q      <= prod_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      res_q       <= res_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = en;
  assign bus.out_valid = out_valid_q;
  assign bus.acc_out   = res_q;
endmodule

// File: tb/tb_mac_accum.sv
// tb_mac_accum: directed self-checking bench for mac_accum (2 lanes, 8-bit
// operands, 4 products per result, 18-bit results).
module tb_mac_accum;
  localparam int unsigned DW = 8;
  localparam int unsigned CH = 2;
  localparam int unsigned AL = 4;
  localparam int unsigned OW = 18;

  logic clk;
  logic reset;
  logic flush;
  logic acc_flag;
  int   n_cmp;
  int   n_fail;

  mac_accum_if #(.DATA_W(DW), .CHANNELS(CH), .ACC_LEN(AL)) bus ();

  mac_accum #(.DATA_W(DW), .CHANNELS(CH), .ACC_LEN(AL)) dut (
    .clk100 (clk),
    .reset  (reset),
    .flush  (flush),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string  name;
    int     a0, b0, a1, b1;
    longint e0, e1;
  } vec_t;

  vec_t vecs[5];

  function automatic logic [15:0] pack(int l0, int l1);
    logic [7:0] x0, x1;
    x0 = 8'(l0);
    x1 = 8'(l1);
    return {x1, x0};
  endfunction

  function automatic longint lane(int i);
    logic [OW-1:0] v;
    v = bus.acc_out[i*OW +: OW];
    return longint'($signed(v));
  endfunction

  task automatic check(string name, longint act, longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One clock: note whether operands are accepted, then step to #1 after the edge.
  task automatic cyc();
    @(negedge clk);
    acc_flag = bus.in_valid && bus.in_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic feed(int a0, int b0, int a1, int b1);
    int n;
    bus.mult_a   = pack(a0, a1);
    bus.mult_b   = pack(b0, b1);
    bus.in_valid = 1'b1;
    n = 0;
    do begin
      cyc();
      n++;
    end while (!acc_flag && n < 20);
    check("feed_accept", acc_flag, 1);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_result(string name, longint e0, longint e1);
    int n;
    n = 0;
    while (!bus.out_valid && n < 20) begin
      cyc();
      n++;
    end
    check({name, "_seen"}, bus.out_valid, 1);
    if (bus.out_valid) begin
      check({name, "_lane0"}, lane(0), e0);
      check({name, "_lane1"}, lane(1), e1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    longint exp0[3];
    longint exp1[3];
    longint prev0, prev1;
    int     k, got;
    bit     prev_stall;

    n_cmp  = 0;
    n_fail = 0;
    vecs[0] = '{"basic",   3,    4,    -2,   5,    48,    -40};
    vecs[1] = '{"extreme", -128, -128, -128, 127,  65536, -65024};
    vecs[2] = '{"maxpos",  127,  127,  -1,   -128, 64516, 512};
    vecs[3] = '{"zero",    0,    -7,   7,    -7,   0,     -196};
    vecs[4] = '{"mixed",   -1,   1,    100,  -3,   -4,    -1200};

    reset         = 1'b1;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.mult_a    = '0;
    bus.mult_b    = '0;
    bus.out_ready = 1'b1;
    repeat (3) cyc();
    reset = 1'b0;
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_lane0", lane(0), 0);
    check("rst_lane1", lane(1), 0);

    // Table vectors: 4 back-to-back sets, result after edge T+2 of last accept.
    for (int v = 0; v < 5; v++) begin
      for (int j = 0; j < 4; j++) feed(vecs[v].a0, vecs[v].b0, vecs[v].a1, vecs[v].b1);
      check({vecs[v].name, "_early0"}, bus.out_valid, 0);
      cyc();
      check({vecs[v].name, "_early1"}, bus.out_valid, 0);
      cyc();
      check({vecs[v].name, "_valid"}, bus.out_valid, 1);
      check({vecs[v].name, "_lane0"}, lane(0), vecs[v].e0);
      check({vecs[v].name, "_lane1"}, lane(1), vecs[v].e1);
      cyc();
      check({vecs[v].name, "_pulse"}, bus.out_valid, 0);
    end

    // Backpressure: a=k,b=1 / a=-k,b=2 for k=1..12, out_ready low then intermittent.
    exp0[0] = 10;  exp0[1] = 26;  exp0[2] = 42;
    exp1[0] = -20; exp1[1] = -52; exp1[2] = -84;
    k = 1;
    got = 0;
    prev_stall = 1'b0;
    prev0 = 0;
    prev1 = 0;
    for (int c = 0; c < 200 && got < 3; c++) begin
      bus.out_ready = (c >= 12) && (c % 3 != 0);
      bus.in_valid  = (k <= 12);
      bus.mult_a    = pack(k, -k);
      bus.mult_b    = pack(1, 2);
      @(negedge clk);
      if (bus.out_valid && !bus.out_ready) begin
        check("bp_in_ready", bus.in_ready, 0);
        if (prev_stall) begin
          check("bp_hold0", lane(0), prev0);
          check("bp_hold1", lane(1), prev1);
        end
        prev_stall = 1'b1;
        prev0 = lane(0);
        prev1 = lane(1);
      end else begin
        prev_stall = 1'b0;
      end
      if (bus.in_valid && bus.in_ready) k++;
      if (bus.out_valid && bus.out_ready) begin
        check("bp_lane0", lane(0), exp0[got]);
        check("bp_lane1", lane(1), exp1[got]);
        got++;
      end
      @(posedge clk);
      #1;
    end
    check("bp_groups", got, 3);
    check("bp_samples", k, 13);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (4) cyc();
    check("bp_idle", bus.out_valid, 0);

    // Gapped input: accepts on every other edge.
    bus.mult_a = pack(3, -2);
    bus.mult_b = pack(4, 5);
    for (int i = 0; i < 8; i++) begin
      bus.in_valid = (i % 2 == 0);
      cyc();
      check("gap_idle", bus.out_valid, 0);
    end
    bus.in_valid = 1'b0;
    cyc();
    check("gap_valid", bus.out_valid, 1);
    check("gap_lane0", lane(0), 48);
    check("gap_lane1", lane(1), -40);
    cyc();

    // Flush while a result is stalled, then flush with operands in the same cycle.
    bus.out_ready = 1'b0;
    for (int j = 0; j < 4; j++) feed(2, 2, -3, 3);
    feed(5, 5, 5, 5);
    feed(5, 5, 5, 5);
    flush        = 1'b1;
    bus.in_valid = 1'b1;
    bus.mult_a   = pack(9, 9);
    bus.mult_b   = pack(9, 9);
    cyc();
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    check("fl_pend_valid", bus.out_valid, 1);
    check("fl_pend_lane0", lane(0), 16);
    check("fl_pend_lane1", lane(1), -36);
    bus.out_ready = 1'b1;
    cyc();
    check("fl_consumed", bus.out_valid, 0);
    feed(5, 5, 5, 5);
    feed(5, 5, 5, 5);
    flush        = 1'b1;
    bus.in_valid = 1'b1;
    bus.mult_a   = pack(9, 9);
    bus.mult_b   = pack(9, 9);
    cyc();
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    for (int j = 0; j < 4; j++) feed(1, 1, -1, 1);
    wait_result("fl_result", 4, -4);
    cyc();

    // Reset with a result pending and partial samples in flight.
    bus.out_ready = 1'b0;
    for (int j = 0; j < 4; j++) feed(7, 1, 7, -1);
    feed(9, 9, 9, 9);
    feed(9, 9, 9, 9);
    check("mr_pending", bus.out_valid, 1);
    reset = 1'b1;
    flush = 1'b1;
    cyc();
    reset = 1'b0;
    flush = 1'b0;
    check("mr_out_valid", bus.out_valid, 0);
    check("mr_lane0", lane(0), 0);
    check("mr_lane1", lane(1), 0);
    check("mr_in_ready", bus.in_ready, 1);
    bus.out_ready = 1'b1;
    for (int j = 0; j < 4; j++) feed(2, 3, 2, -3);
    wait_result("mr_result", 24, -24);
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
